// File: rtl/ccff_stream_loader.sv
// Streams bitstream words LSB-first into the fabric configuration chain and holds I/O isolated until CHAIN_LEN bits are loaded.
// Optional feature: define CCFF_LOADER_PARITY_EN for even-parity checking of each fetched word (adds in_parity).
module ccff_stream_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
`ifdef CCFF_LOADER_PARITY_EN
    input  logic              in_parity,
`endif
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BL_W = $clog2(CHAIN_LEN + 1);
    localparam int WL_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg;
    logic [BL_W-1:0]   bits_left;
    logic [WL_W-1:0]   word_left;
    logic              parity_ok;

`ifdef CCFF_LOADER_PARITY_EN
    assign parity_ok = ~(^in_data ^ in_parity);
    assign error     = (state_q == S_ERR);
`else
    assign parity_ok = 1'b1;
    assign error     = 1'b0;
`endif

    always_ff @(posedge prog_clk) begin
        if (pReset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (in_valid) state_d = parity_ok ? S_SHIFT : S_ERR;
            end
            S_SHIFT: begin
                // Last bit of this word: either the chain is full or we need another word.
                if (word_left == WL_W'(1))
                    state_d = (bits_left == BL_W'(1)) ? S_DONE : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sreg      <= '0;
            bits_left <= '0;
            word_left <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) bits_left <= BL_W'(CHAIN_LEN);
                end
                S_FETCH: begin
                    if (in_valid && parity_ok) begin
                        sreg <= in_data;
                        // A short final word only shifts what the chain still needs.
                        if (int'(bits_left) >= WORD_W) word_left <= WL_W'(WORD_W);
                        else                           word_left <= WL_W'(bits_left);
                    end
                end
                S_SHIFT: begin
                    sreg      <= sreg >> 1;
                    word_left <= word_left - 1'b1;
                    bits_left <= bits_left - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (state_q == S_FETCH);
    assign ccff_shift_en = (state_q == S_SHIFT);
    assign ccff_head     = (state_q == S_SHIFT) & sreg[0];
    assign busy          = (state_q == S_FETCH) | (state_q == S_SHIFT);
    assign done          = (state_q == S_DONE);
    assign IO_ISOL_N     = (state_q == S_DONE);

endmodule
